mod6_sequence_monitor: RTL and testbench
========================================

# mod6_sequence_monitor

Downstream checker for the mod-6 sequence generator. It samples the generator's 4-bit count on every rising clock edge and confirms that the count is legal (0..5). It also confirms each step is a +1 step that wraps from 5 to 0. From those samples it produces a lock indication, a per-wrap pulse, a saturating wrap counter and a saturating error counter. The next stage and the bench use it as a self-checking consumer of the counter output.

## Interface
Parameters:
- MOD, 6: modulus of the monitored sequence; legal values are 0..MOD-1.
- WIDTH, 4: width of the monitored count.
- LOCK_LEN, 3: consecutive good steps required to declare lock (≥1).
- CNT_W, 8: width of wrap_count and err_count.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- count_in, input, WIDTH: counter value under test, sampled every rising edge.
- locked, output, 1: high while in state LOCKED.
- wrap_pulse, output, 1: one-cycle pulse for each legal (MOD-1)→0 step seen while LOCKED.
- wrap_count, output, CNT_W: number of wrap_pulse events; saturates at all-ones.
- err_pulse, output, 1: one-cycle pulse on each failed step seen while LOCKED.
- err_count, output, CNT_W: number of err_pulse events; saturates at all-ones.
- fault, output, 1: high while in state FAULT.

## Operation
- Internal registers:
  - prev: last sampled value.
  - prev_valid: set when prev holds a legal value.
  - good_run: count of consecutive good steps, width ≥ clog2(LOCK_LEN+1).
  - state: one of ACQUIRE, LOCKED, FAULT.
- Per-edge combinational terms:
  - legal = count_in < MOD.
  - expect = (prev == MOD-1) ? 0 : prev+1.
  - step_ok = legal && prev_valid && count_in == expect.
- Every edge: prev ← count_in; prev_valid ← legal.
- State transitions:
  - ACQUIRE:
    - step_ok: good_run+1.
    - good_run+1 == LOCK_LEN: go to LOCKED.
    - !step_ok: good_run ← 0. No error is counted while acquiring.
  - LOCKED:
    - step_ok: stay. If count_in == 0, pulse wrap_pulse and increment wrap_count (saturating).
    - !step_ok: go to FAULT, pulse err_pulse, increment err_count (saturating).
  - FAULT:
    - step_ok: go to ACQUIRE with good_run ← 1. If LOCK_LEN == 1, go directly to LOCKED instead.
    - otherwise: stay in FAULT. No further err_pulse fires until lock is regained.
- An illegal value (≥ MOD) is never a valid step, whether it is the current sample or the predecessor. The first legal value after an illegal one only reseeds prev.
- The first sample after reset only seeds prev; it is never checked.

## Timing
- Reset values: locked=0, wrap_pulse=0, wrap_count=0, err_pulse=0, err_count=0, fault=0, state=ACQUIRE, prev=0, prev_valid=0, good_run=0.
- All outputs are registered. An event sampled at edge N is visible after edge N and holds for one cycle (pulses) or until the next change (levels).
- Lock latency for a clean sequence: first sample at edge 0, LOCK_LEN good steps at edges 1..LOCK_LEN, locked=1 after edge LOCK_LEN.
- Wrap with simultaneous saturation: wrap_pulse still asserts and wrap_count holds at max. The same rule applies to err_count.
- Reset asserted mid-operation:
  - All outputs clear without waiting for a clock edge.
  - The first edge after reset deasserts counts as the seed sample.
- Count held constant (stalled counter): a failed step. From LOCKED it goes to FAULT; from ACQUIRE it clears good_run.

## Structure
- Shared package mod6_pkg holds:
  - the state enum (ACQUIRE, LOCKED, FAULT);
  - default constants MOD_DEFAULT=6 and COUNT_WIDTH=4, shared with the generator.
- One natural sub-module: sat_counter, a parameterised CNT_W saturating incrementer with an inc input. Instantiate it twice, once for wraps and once for errors.
- The step checker and the FSM stay in the top module.

## Test plan
- Clean sequence 0,1,2,3,4,5,0,… from reset → locked=1 after edge 3; wrap_pulse fires exactly on each 5→0 step; wrap_count=2 after the second wrap; err_count=0.
- While locked, inject 2 in place of 4 (…,3,2,…) → err_pulse for one cycle, fault=1, locked=0, err_count=1. Resume from 3,4,5 → locked again after 3 good steps.
- Inject illegal value 7 while locked → err_count=1. Sequence 0,1,2,3 afterwards: 0 only reseeds, locked=1 after the sample 3.
- Hold count_in at 3 for 4 cycles while locked → exactly one err_pulse, err_count=1, fault held until the next good step.
- Assert reset asynchronously between edges while locked with wrap_count=5 → all outputs read 0 before the next edge; relock takes LOCK_LEN+1 samples.
- Run CNT_W=2 with 5 wraps → wrap_count saturates at 3, and wrap_pulse still fires on the 4th and 5th wraps.

Source files
------------

// File: rtl/mod6_pkg.sv
// Shared definitions for the mod-6 generator/monitor pair.
package mod6_pkg;

    // Defaults shared with the sequence generator.
    localparam int MOD_DEFAULT = 6;
    localparam int COUNT_WIDTH = 4;

    // Monitor lock state.
    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/mod6_sequence_monitor_if.sv
// Count-in / status bundle between a mod-N generator and its monitor.
interface mod6_sequence_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic             wrap_pulse;
    logic [CNT_W-1:0] wrap_count;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             fault;

    // Generator/observer side: drives the count, watches status.
    modport master (
        output count_in,
        input  locked, wrap_pulse, wrap_count, err_pulse, err_count, fault
    );

    // Monitor side: samples the count, reports status.
    modport slave (
        input  count_in,
        output locked, wrap_pulse, wrap_count, err_pulse, err_count, fault
    );
endinterface

// File: rtl/mod6_sequence_monitor_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, holding at max once reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mod6_sequence_monitor.sv
// Checks that a mod-N counter steps +1 with wrap, tracks lock, counts wraps/errors.
module mod6_sequence_monitor
    import mod6_pkg::*;
#(
    parameter int MOD      = MOD_DEFAULT,
    parameter int WIDTH    = COUNT_WIDTH,
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input logic                   clock,
    input logic                   reset,
    mod6_sequence_monitor_if.slave mon
);

    localparam int GR_W = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);

    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [GR_W-1:0]  good_run, good_run_n, good_run_inc;
    mon_state_e       state, state_n;

    logic             legal;
    logic [WIDTH-1:0] expect_v;
    logic             step_ok;
    logic             wrap_ev, err_ev;
    logic             wrap_pulse_q, err_pulse_q;

    // Step checker: an illegal sample or an illegal predecessor never forms a good step.
    always_comb begin
        legal    = (int'(mon.count_in) < MOD);
        expect_v = (prev == WIDTH'(MOD - 1)) ? '0 : prev + 1'b1;
        step_ok  = legal && prev_valid && (mon.count_in == expect_v);
    end

    assign good_run_inc = good_run + 1'b1;

    // Lock FSM next state, good-run tracking and event strobes.
    always_comb begin
        state_n    = state;
        good_run_n = good_run;
        wrap_ev    = 1'b0;
        err_ev     = 1'b0;
        case (state)
            ACQUIRE: begin
                if (step_ok) begin
                    if (int'(good_run_inc) >= LOCK_LEN) begin
                        state_n    = LOCKED;
                        good_run_n = '0;
                    end else begin
                        good_run_n = good_run_inc;
                    end
                end else begin
                    good_run_n = '0;
                end
            end
            LOCKED: begin
                if (step_ok) begin
                    wrap_ev = (mon.count_in == '0);
                end else begin
                    state_n = FAULT;
                    err_ev  = 1'b1;
                end
            end
            FAULT: begin
                // One good step restarts acquisition with that step already counted.
                if (step_ok) begin
                    if (LOCK_LEN <= 1) begin
                        state_n    = LOCKED;
                        good_run_n = '0;
                    end else begin
                        state_n    = ACQUIRE;
                        good_run_n = GR_W'(1);
                    end
                end
            end
            default: begin
                state_n    = ACQUIRE;
                good_run_n = '0;
            end
        endcase
    end

    // State, history and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ACQUIRE;
            good_run     <= '0;
            prev         <= '0;
            prev_valid   <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state        <= state_n;
            good_run     <= good_run_n;
            prev         <= mon.count_in;
            prev_valid   <= legal;
            wrap_pulse_q <= wrap_ev;
            err_pulse_q  <= err_ev;
        end
    end

    logic [CNT_W-1:0] wrap_count_q, err_count_q;

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wrap_ev),
        .count (wrap_count_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (err_ev),
        .count (err_count_q)
    );

    assign mon.locked     = (state == LOCKED);
    assign mon.fault      = (state == FAULT);
    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.wrap_count = wrap_count_q;
    assign mon.err_count  = err_count_q;

endmodule

// File: tb/tb_mod6_sequence_monitor.sv
// Directed bench: default monitor plus a CNT_W=2 copy fed the same count stream.
module tb_mod6_sequence_monitor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    mod6_sequence_monitor_if #(.WIDTH(4), .CNT_W(8)) ifc ();
    mod6_sequence_monitor_if #(.WIDTH(4), .CNT_W(2)) ifc2 ();

    mod6_sequence_monitor #(.MOD(6), .WIDTH(4), .LOCK_LEN(3), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .mon   (ifc)
    );

    mod6_sequence_monitor #(.MOD(6), .WIDTH(4), .LOCK_LEN(3), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .mon   (ifc2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one sample; returns 1ns after the edge that captured it.
    task automatic cyc(input logic [3:0] v);
        @(negedge clock);
        ifc.count_in  = v;
        ifc2.count_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".locked"},     32'(ifc.locked),     0);
        chk({tag, ".fault"},      32'(ifc.fault),      0);
        chk({tag, ".wrap_pulse"}, 32'(ifc.wrap_pulse), 0);
        chk({tag, ".err_pulse"},  32'(ifc.err_pulse),  0);
        chk({tag, ".wrap_count"}, 32'(ifc.wrap_count), 0);
        chk({tag, ".err_count"},  32'(ifc.err_count),  0);
    endtask

    initial begin
        ifc.count_in  = '0;
        ifc2.count_in = '0;
        #12;
        chk_all_zero("rst");
        reset = 1'b0;

        // Clean sequence: seed 0, good steps 1,2,3 -> locked after 3.
        cyc(0); cyc(1); cyc(2);
        chk("clean.locked_early", 32'(ifc.locked), 0);
        cyc(3);
        chk("clean.locked", 32'(ifc.locked), 1);
        cyc(4); cyc(5);
        chk("clean.no_wrap_yet", 32'(ifc.wrap_pulse), 0);
        cyc(0);
        chk("clean.wrap1_pulse", 32'(ifc.wrap_pulse), 1);
        chk("clean.wrap1_cnt",   32'(ifc.wrap_count), 1);
        cyc(1);
        chk("clean.wrap_pulse_low", 32'(ifc.wrap_pulse), 0);
        cyc(2); cyc(3); cyc(4); cyc(5); cyc(0);
        chk("clean.wrap2_pulse", 32'(ifc.wrap_pulse), 1);
        chk("clean.wrap2_cnt",   32'(ifc.wrap_count), 2);
        chk("clean.err_cnt",     32'(ifc.err_count),  0);

        // Bad step 3->2 while locked.
        cyc(1); cyc(2); cyc(3); cyc(2);
        chk("skip.err_pulse", 32'(ifc.err_pulse), 1);
        chk("skip.fault",     32'(ifc.fault),     1);
        chk("skip.locked",    32'(ifc.locked),    0);
        chk("skip.err_cnt",   32'(ifc.err_count), 1);
        cyc(3);
        chk("skip.err_pulse_low", 32'(ifc.err_pulse), 0);
        chk("skip.fault_clr",     32'(ifc.fault),     0);
        cyc(4);
        chk("skip.not_yet", 32'(ifc.locked), 0);
        cyc(5);
        chk("skip.relock",  32'(ifc.locked), 1);
        chk("skip.err_cnt_hold", 32'(ifc.err_count), 1);

        // Illegal value 7 while locked; 0 after it only reseeds.
        do_reset();
        cyc(0); cyc(1); cyc(2); cyc(3);
        chk("ill.locked", 32'(ifc.locked), 1);
        cyc(4); cyc(7);
        chk("ill.err_pulse", 32'(ifc.err_pulse), 1);
        chk("ill.err_cnt",   32'(ifc.err_count), 1);
        chk("ill.fault",     32'(ifc.fault),     1);
        cyc(0);
        chk("ill.reseed_fault", 32'(ifc.fault),     1);
        chk("ill.reseed_err",   32'(ifc.err_count), 1);
        cyc(1);
        chk("ill.acq", 32'(ifc.fault), 0);
        cyc(2);
        chk("ill.not_yet", 32'(ifc.locked), 0);
        cyc(3);
        chk("ill.relock", 32'(ifc.locked), 1);

        // Stalled counter: one error only, fault held until a good step.
        do_reset();
        cyc(0); cyc(1); cyc(2); cyc(3);
        chk("stall.locked", 32'(ifc.locked), 1);
        cyc(3);
        chk("stall.err_pulse", 32'(ifc.err_pulse), 1);
        chk("stall.err_cnt",   32'(ifc.err_count), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(3);
            chk("stall.hold_pulse", 32'(ifc.err_pulse), 0);
            chk("stall.hold_fault", 32'(ifc.fault),     1);
            chk("stall.hold_cnt",   32'(ifc.err_count), 1);
        end
        cyc(4);
        chk("stall.fault_clr", 32'(ifc.fault), 0);

        // Five wraps; the CNT_W=2 copy saturates at 3 but keeps pulsing.
        do_reset();
        cyc(0);
        for (int w = 1; w <= 5; w++) begin
            for (int v = 1; v <= 5; v++) cyc(4'(v));
            cyc(0);
            chk("wrap.pulse",   32'(ifc.wrap_pulse),  1);
            chk("wrap.cnt",     32'(ifc.wrap_count),  32'(w));
            chk("sat.pulse",    32'(ifc2.wrap_pulse), 1);
            chk("sat.cnt",      32'(ifc2.wrap_count), (w > 3) ? 32'd3 : 32'(w));
        end
        cyc(1);
        chk("arst.pre_locked", 32'(ifc.locked), 1);
        chk("arst.pre_wraps",  32'(ifc.wrap_count), 5);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        chk("arst.sat_cnt", 32'(ifc2.wrap_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(2); cyc(3); cyc(4);
        chk("arst.not_yet", 32'(ifc.locked), 0);
        cyc(5);
        chk("arst.relock", 32'(ifc.locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
